// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data SRAM port arbiter: requester identity and
// the in-flight response tag carried alongside each SRAM access.
package mem_arb_pkg;

  localparam int MEM_LATENCY_MAX = 4;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_write;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_INST, is_write: 1'b0};

endpackage

// File: rtl/resp_tag_pipe.sv
// Fixed-depth shift register of response tags; the last stage lines up with
// the SRAM read data returning DEPTH cycles after the access was issued.
module resp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic i_clear,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [DEPTH];

  // NOTE: the tag stages are cleared on reset even though they form a small
  // memory; a stale valid bit would surface as a phantom response later.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= TAG_IDLE;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage take its neighbour's
      // pre-edge value, so the loop order does not matter.
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between fetch (read-only) and data (read/write).
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX losses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic w_inst_win;
  logic w_data_win;
  logic w_starve_fire;
  tag_t w_tag_in;
  tag_t w_resp_tag;

`ifdef ARB_STARVE_GUARD_EN
  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_starve_fire = (r_starve_cnt == CNT_MAX);

  // Counts consecutive cycles in which fetch was waiting and data took the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!inst_req || w_inst_win) begin
      r_starve_cnt <= '0;
    end else if (w_data_win && (r_starve_cnt != CNT_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  // Strict data priority; STARVE_MAX is at least 1, so this is constant 0.
  assign w_starve_fire = (STARVE_MAX == 0);
`endif

  // NOTE: every output of this block gets a default first, so no path through
  // the if/else can leave a signal unassigned and infer a latch.
  always_comb begin
    w_inst_win = 1'b0;
    w_data_win = 1'b0;
    mem_en     = 1'b0;
    mem_wen    = 4'b0;
    mem_addr   = 32'b0;
    mem_wdata  = 32'b0;
    w_tag_in   = TAG_IDLE;

    if (!reset) begin
      w_inst_win = inst_req && (!data_req || w_starve_fire);
      w_data_win = data_req && !w_inst_win;
    end

    if (w_inst_win) begin
      mem_en         = 1'b1;
      mem_addr       = inst_addr;
      w_tag_in.valid = 1'b1;
      w_tag_in.owner = OWN_INST;
    end else if (w_data_win) begin
      mem_en            = 1'b1;
      mem_wen           = data_wen;
      mem_addr          = data_addr;
      mem_wdata         = data_wdata;
      w_tag_in.valid    = 1'b1;
      w_tag_in.owner    = OWN_DATA;
      w_tag_in.is_write = |data_wen;
    end
  end

  assign inst_gnt = w_inst_win;
  assign data_gnt = w_data_win;

  resp_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_resp_tag_pipe (
    .clk     (clk),
    .i_clear (reset),
    .i_tag   (w_tag_in),
    .o_tag   (w_resp_tag)
  );

  // The pipe clears on the edge ending reset, so gate responses during it too.
  always_comb begin
    inst_rvalid = 1'b0;
    inst_rdata  = 32'b0;
    data_rvalid = 1'b0;
    data_rdata  = 32'b0;
    if (!reset && w_resp_tag.valid) begin
      if (w_resp_tag.owner == OWN_INST) begin
        inst_rvalid = 1'b1;
        inst_rdata  = mem_rdata;
      end else begin
        data_rvalid = 1'b1;
        if (!w_resp_tag.is_write) begin
          data_rdata = mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified SRAM between the fetch stage (read-only) and the memory stage (read/write) of the 5-stage CPU. Grants at most one access per cycle, with data priority and an optional anti-starvation guard for fetch. Tracks in-flight accesses in a tag pipeline so each read/write response returns to the requester that issued it. Sits between the pipeline stages and the external SRAM interface at CPU top level.

## Interface

Parameters:
- MEM_LATENCY, 1: cycles from mem_en to valid mem_rdata; legal range 1..4.
- STARVE_MAX, 4: consecutive fetch losses before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held high until inst_gnt.
- inst_addr  in  32  fetch byte address.
- inst_gnt  out  1  fetch request accepted this cycle.
- inst_rvalid  out  1  fetch read data valid.
- inst_rdata  out  32  fetch read data; 0 when inst_rvalid low.
- data_req  in  1  data request; held high until data_gnt.
- data_wen  in  4  byte write enables; 0 = read.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data.
- data_gnt  out  1  data request accepted this cycle.
- data_rvalid  out  1  data response (read data or write completion).
- data_rdata  out  32  data read data; 0 when data_rvalid low or response is a write.
- mem_en  out  1  SRAM enable.
- mem_wen  out  4  SRAM byte write enables.
- mem_addr  out  32  SRAM address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid MEM_LATENCY cycles after mem_en.

## Operation

- Arbitration is combinational within the cycle.
  - Only one req high: that requester is granted.
  - Both high: data wins, unless the starvation guard fires (see Configuration).
  - Neither high: no grant, mem_en=0, mem_wen=0, mem_addr/mem_wdata=0.
- On a grant, mem_* are driven from the winner's inputs. Fetch always drives mem_wen=0 and mem_wdata=0.
- Each cycle a tag {valid, owner (INST/DATA), is_write} enters the tag pipeline. valid=0 when no grant.
- Tag at pipeline depth MEM_LATENCY selects the response:
  - valid & INST: inst_rvalid=1, inst_rdata=mem_rdata.
  - valid & DATA & read: data_rvalid=1, data_rdata=mem_rdata.
  - valid & DATA & write: data_rvalid=1, data_rdata=0.
- Requests are never queued. A denied requester simply keeps req high.
- Address and data pass through unchanged; no alignment checks.

## Timing

- Grant latency: 0 cycles (gnt in the same cycle as req when the requester wins).
- Response latency: exactly MEM_LATENCY cycles after the grant cycle.
- Throughput: one access per cycle; back-to-back grants to the same requester are allowed.
- Responses return in grant order; at most one rvalid per cycle across both requesters.
- Reset (sync, active-high), while reset is high:
  - all gnt, rvalid and mem_en forced to 0; rdata outputs 0; mem_* outputs 0;
  - tag pipeline cleared; starvation counter cleared.
- Reset mid-operation: in-flight responses are discarded and never signalled, including after reset deasserts.
- First grant possible in the first cycle with reset low.

## Configuration

- ARB_STARVE_GUARD_EN defined: a starve counter counts cycles where inst_req=1 and data won.
  - When the count equals STARVE_MAX, fetch wins that cycle and the counter clears.
  - The counter also clears whenever inst_req=0 or fetch is granted, and saturates at STARVE_MAX.
  - Width is clog2(STARVE_MAX+1).
- ARB_STARVE_GUARD_EN undefined: strict data priority; no counter logic is present. Fetch can starve indefinitely.

## Structure

- Package mem_arb_pkg:
  - owner enum (OWN_INST, OWN_DATA);
  - tag struct {valid, owner, is_write};
  - MEM_LATENCY_MAX = 4.
- Sub-module resp_tag_pipe: MEM_LATENCY-deep shift register of tags with synchronous clear. Its output is the response tag.
- All arbitration and starve-counter logic lives in the top module.

## Test plan

- Fetch only, MEM_LATENCY=1: inst_req=1, inst_addr=0xBFC00000 → inst_gnt=1 same cycle, mem_addr=0xBFC00000, mem_wen=0; next cycle inst_rvalid=1 and inst_rdata equals mem_rdata.
- Simultaneous requests, guard undefined, 10 cycles: data_gnt=1 every cycle, inst_gnt=0 throughout, mem_addr always equals data_addr.
- Guard defined, STARVE_MAX=4, both req held high:
  - grants follow D,D,D,D,I,D,D,D,D,I…;
  - inst_rvalid follows each I grant by MEM_LATENCY.
- Store then load, MEM_LATENCY=3:
  - data_wen=0xF, addr 0x100, wdata 0xDEADBEEF → data_rvalid at +3 with data_rdata=0;
  - load of 0x100 next cycle → data_rvalid at +4, data_rdata=mem_rdata.
- Reset mid-flight, MEM_LATENCY=2: grant a fetch, assert reset next cycle → inst_rvalid never asserts; all outputs 0 during reset.
- Interleaved traffic, MEM_LATENCY=4: alternating data/fetch grants each cycle → rvalid ownership order matches grant order exactly, with no cycle showing both rvalids high.
